// File: rtl/sort_mem_responder.sv
// rtl/sort_mem_responder.sv - single-port 64-bit word memory responder for the sorting engines
module sort_mem_responder #(
  parameter int unsigned DEPTH      = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        err_sticky
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_INIT = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    lat_q;
  logic [63:0]   mem_q [DEPTH];
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [63:0]   rsp_rdata_q;
  logic [31:0]   rd_count_q;
  logic [31:0]   wr_count_q;
  logic          err_sticky_q;

  logic [63:0]   off_d;
  logic          in_range_d;
  logic [AW-1:0] index_d;
  logic [63:0]   rdata_d;
  logic          accept_d;

  // Below-base addresses wrap to huge offsets, so both tests are needed to reject aliases.
  always_comb begin
    off_d      = req_addr - BASE_ADDR;
    in_range_d = (req_addr >= BASE_ADDR) && (off_d < 64'(DEPTH));
    index_d    = off_d[AW-1:0];
    rdata_d    = (in_range_d && !req_write) ? mem_q[index_d] : 64'h0;
    accept_d   = (state_q == IDLE) && req_valid && req_ready_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      lat_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 64'h0;
      rd_count_q   <= 32'd0;
      wr_count_q   <= 32'd0;
      err_sticky_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 64'h0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q     <= WAIT;
            req_ready_q <= 1'b0;
            lat_q       <= LAT_INIT;
            rsp_err_q   <= !in_range_d;
            rsp_rdata_q <= rdata_d;
            if (req_write && in_range_d) begin
              mem_q[index_d] <= req_wdata;
            end
            if (req_write) begin
              wr_count_q <= wr_count_q + 32'd1;
            end else begin
              rd_count_q <= rd_count_q + 32'd1;
            end
            if (!in_range_d) begin
              err_sticky_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (lat_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        RESP: begin
          // req_ready only returns here, so a request cannot be taken on the handshake edge.
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
  assign err_sticky = err_sticky_q;

endmodule
